cpu_sequencer: RTL and testbench

//  Fetch/execute controller for the 16-bit accumulator CPU. Fetches instruction bytes over a shared
//  8-bit req/ack memory bus, holds IR and data byte, gates decoder enable, and resolves RAM operands.

---
 rtl/cpu_sequencer_pkg.sv | 31 +++
 rtl/cpu_sequencer_bus_if.sv | 34 +++
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the accumulator CPU fetch/execute sequencer.
// Holds the sequencer state encoding, instruction source codes and the RAM window address helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_HI,
        FETCH_LO,
        DECODE,
        FETCH_DATA,
        RAM_HI,
        RAM_LO,
        EXEC
    } seq_state_t;

    // Source field codes found in ir[10:8]
    localparam logic [2:0] SRC_IMM_LO = 3'b000;
    localparam logic [2:0] SRC_IMM_HI = 3'b001;
    localparam logic [2:0] SRC_DATA   = 3'b010;
    localparam logic [2:0] SRC_RAM    = 3'b100;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [15:0] DEFAULT_RAM_BASE = 16'hFE00;

    // Word n of the RAM window lives at base+2n (high byte) and base+2n+1 (low byte)
    function automatic logic [15:0] ram_addr(input logic [15:0] base,
                                             input logic [7:0]  word_idx,
                                             input logic        lo_byte);
        return base + {7'b0, word_idx, lo_byte};
    endfunction

endpackage

// File: rtl/cpu_sequencer_bus_if.sv
// Single-read req/ack engine for the shared 8-bit memory bus.
// mem_req is registered, so it is always low for at least one cycle between transactions.
module seq_bus_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        done,
    output logic [7:0]  rdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (mem_req) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end else if (start) begin
            mem_req  <= 1'b1;
            mem_addr <= addr;
        end
    end

    // An ack seen while no request is outstanding never completes anything
    assign done  = mem_req & mem_ack;
    assign rdata = mem_rdata;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 16-bit accumulator CPU; owns the PC, IR and data byte.
// Optional build macro SEQ_SINGLE_STEP_EN adds a 'step' input that gates each instruction start.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [15:0] RAM_BASE = DEFAULT_RAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        dec_en,
    output logic [15:0] ir,
    output logic [7:0]  data_byte,
    input  logic        dec_nop,
    input  logic        dec_load,
    input  logic        dec_add,
    input  logic        dec_branch,
    input  logic        dec_out_lo,
    input  logic        dec_src_imm,
    input  logic        dec_src_ram,
    input  logic [15:0] dec_rhs,
    output logic [15:0] operand,
    output logic        exec_load,
    output logic        exec_add,
    output logic        exec_out_lo,
    output logic        illegal,
    output logic [15:0] pc
);

    seq_state_t  state;
    logic [15:0] ram_word;
    logic        bus_start;
    logic [15:0] bus_addr;
    logic        bus_done;
    logic [7:0]  bus_rdata;
    logic        step_go;
    logic        unused_src_imm;

    assign unused_src_imm = dec_src_imm;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b1;
`endif

    always_comb begin
        bus_start = 1'b0;
        bus_addr  = pc;
        case (state)
            FETCH_HI:             bus_start = step_go;
            FETCH_LO, FETCH_DATA: bus_start = 1'b1;
            RAM_HI: begin
                bus_start = 1'b1;
                bus_addr  = ram_addr(RAM_BASE, ir[7:0], 1'b0);
            end
            RAM_LO: begin
                bus_start = 1'b1;
                bus_addr  = ram_addr(RAM_BASE, ir[7:0], 1'b1);
            end
            default: bus_start = 1'b0;
        endcase
    end

    seq_bus_if u_bus (
        .clk       (clk),
        .rst       (rst),
        .start     (bus_start),
        .addr      (bus_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (bus_done),
        .rdata     (bus_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_HI;
            pc          <= RESET_PC;
            ir          <= '0;
            data_byte   <= '0;
            ram_word    <= '0;
            operand     <= '0;
            dec_en      <= 1'b0;
            exec_load   <= 1'b0;
            exec_add    <= 1'b0;
            exec_out_lo <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            exec_load   <= 1'b0;
            exec_add    <= 1'b0;
            exec_out_lo <= 1'b0;
            illegal     <= 1'b0;
            case (state)
                FETCH_HI: if (bus_done) begin
                    ir[15:8] <= bus_rdata;
                    pc       <= pc + 16'd1;
                    state    <= FETCH_LO;
                end
                FETCH_LO: if (bus_done) begin
                    ir[7:0] <= bus_rdata;
                    pc      <= pc + 16'd1;
                    dec_en  <= 1'b1;
                    state   <= DECODE;
                end
                DECODE: begin
                    if ((dec_load || dec_add) && ir[10:9] == SRC_DATA[2:1]) begin
                        dec_en <= 1'b0;
                        state  <= FETCH_DATA;
                    end else if (dec_src_ram) begin
                        dec_en <= 1'b0;
                        state  <= RAM_HI;
                    end else begin
                        state  <= EXEC;
                    end
                end
                FETCH_DATA: if (bus_done) begin
                    data_byte <= bus_rdata;
                    pc        <= pc + 16'd1;
                    dec_en    <= 1'b1;
                    state     <= EXEC;
                end
                RAM_HI: if (bus_done) begin
                    ram_word[15:8] <= bus_rdata;
                    state          <= RAM_LO;
                end
                RAM_LO: if (bus_done) begin
                    ram_word[7:0] <= bus_rdata;
                    dec_en        <= 1'b1;
                    state         <= EXEC;
                end
                EXEC: begin
                    // Strobes and operand appear together in the cycle after EXEC
                    dec_en  <= 1'b0;
                    state   <= FETCH_HI;
                    operand <= dec_src_ram ? ram_word : dec_rhs;
                    if (dec_branch) begin
                        pc <= {5'b0, dec_rhs[10:0]};
                    end else if (dec_load) begin
                        exec_load <= 1'b1;
                    end else if (dec_add) begin
                        exec_add <= 1'b1;
                    end else if (dec_out_lo) begin
                        exec_out_lo <= 1'b1;
                    end else if (!dec_nop) begin
                        illegal <= 1'b1;
                    end
                end
                default: begin
                    dec_en <= 1'b0;
                    state  <= FETCH_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory responder, decoder model and per-instruction checks.
// Runs a small program from RESET_PC=0xFFFF covering wrap, immediates, data byte, RAM, nop, illegal, branch and reset.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        dec_en;
    logic [15:0] ir;
    logic [7:0]  data_byte;
    logic        dec_nop, dec_load, dec_add, dec_branch, dec_out_lo;
    logic        dec_src_imm, dec_src_ram;
    logic [15:0] dec_rhs;
    logic [15:0] operand;
    logic        exec_load, exec_add, exec_out_lo, illegal;
    logic [15:0] pc;

    logic [7:0]  mem [0:65535];
    logic [15:0] txn_q [$];
    logic        stall;
    logic        spurious;
    int          vectors;
    int          miscompares;

    typedef struct {
        logic [15:0] ir_w;
        logic [15:0] next_pc;
        logic [15:0] code;
        logic        op_chk;
        logic [15:0] op;
        logic        db_chk;
        logic [7:0]  db;
        int          ntx;
        logic [15:0] tx [4];
    } vec_t;

    vec_t vecs [10];

    cpu_sequencer #(.RESET_PC(16'hFFFF), .RAM_BASE(16'hFE00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .dec_en      (dec_en),
        .ir          (ir),
        .data_byte   (data_byte),
        .dec_nop     (dec_nop),
        .dec_load    (dec_load),
        .dec_add     (dec_add),
        .dec_branch  (dec_branch),
        .dec_out_lo  (dec_out_lo),
        .dec_src_imm (dec_src_imm),
        .dec_src_ram (dec_src_ram),
        .dec_rhs     (dec_rhs),
        .operand     (operand),
        .exec_load   (exec_load),
        .exec_add    (exec_add),
        .exec_out_lo (exec_out_lo),
        .illegal     (illegal),
        .pc          (pc)
    );

    // Decoder model: 00=nop, 10=ALU (op in [13:11], source in [10:8]), 11=branch, 01=no class
    logic is_alu;
    assign is_alu      = (ir[15:14] == 2'b10);
    assign dec_nop     = (ir[15:14] == 2'b00);
    assign dec_branch  = (ir[15:14] == 2'b11);
    assign dec_load    = is_alu && (ir[13:11] == 3'b000);
    assign dec_add     = is_alu && (ir[13:11] == 3'b001);
    assign dec_out_lo  = is_alu && (ir[13:11] == 3'b010);
    assign dec_src_imm = is_alu && (ir[10:8] == SRC_IMM_LO || ir[10:8] == SRC_IMM_HI);
    assign dec_src_ram = is_alu && (ir[10:8] == SRC_RAM);
    assign dec_rhs     = dec_branch               ? {5'b0, ir[10:0]} :
                         (ir[10:8] == SRC_IMM_HI) ? {ir[7:0], 8'h00} :
                         (ir[10:9] == 2'b01)      ? {8'h00, data_byte} :
                                                    {8'h00, ir[7:0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory responder: ack on the second cycle a request is seen
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req && !stall) begin
                cnt++;
                if (cnt >= 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    txn_q.push_back(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                cnt       = 0;
                mem_ack   = !mem_req && spurious;
                mem_rdata = spurious ? 8'hAA : 8'h00;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] ir_w, input logic [15:0] next_pc,
                                input logic [15:0] code, input logic op_chk, input logic [15:0] op,
                                input logic db_chk, input logic [7:0] db, input int ntx,
                                input logic [15:0] t0, input logic [15:0] t1,
                                input logic [15:0] t2, input logic [15:0] t3);
        vec_t v;
        v.ir_w    = ir_w;
        v.next_pc = next_pc;
        v.code    = code;
        v.op_chk  = op_chk;
        v.op      = op;
        v.db_chk  = db_chk;
        v.db      = db;
        v.ntx     = ntx;
        v.tx[0]   = t0;
        v.tx[1]   = t1;
        v.tx[2]   = t2;
        v.tx[3]   = t3;
        return v;
    endfunction

    // Runs one instruction: observes until the next instruction's first fetch request rises
    task automatic applyStimulus(input int idx);
        vec_t        v;
        int          cyc, nl, na, no, ni, nde;
        logic [15:0] op_s;
        logic        prev_req;
        logic        hit;
        v        = vecs[idx];
        txn_q.delete();
        cyc      = 0;
        nl       = 0;
        na       = 0;
        no       = 0;
        ni       = 0;
        nde      = 0;
        op_s     = 16'h0000;
        prev_req = 1'b1;
        hit      = 1'b0;
        while (!hit && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exec_load)   nl++;
            if (exec_add)    na++;
            if (exec_out_lo) no++;
            if (illegal)     ni++;
            if (dec_en)      nde++;
            if (exec_load || exec_add || exec_out_lo || illegal) op_s = operand;
            if (mem_req && !prev_req && mem_addr == v.next_pc) hit = 1'b1;
            prev_req = mem_req;
        end
        checkOutput($sformatf("v%0d_next_fetch", idx), {31'b0, hit}, 32'd1);
        checkOutput($sformatf("v%0d_strobes", idx), {16'b0, 4'(nl), 4'(na), 4'(no), 4'(ni)}, {16'b0, v.code});
        checkOutput($sformatf("v%0d_ir", idx), {16'b0, ir}, {16'b0, v.ir_w});
        checkOutput($sformatf("v%0d_pc", idx), {16'b0, pc}, {16'b0, v.next_pc});
        checkOutput($sformatf("v%0d_dec_en_cycles", idx), nde, 32'd2);
        if (v.op_chk) checkOutput($sformatf("v%0d_operand", idx), {16'b0, op_s}, {16'b0, v.op});
        if (v.db_chk) checkOutput($sformatf("v%0d_data_byte", idx), {24'b0, data_byte}, {24'b0, v.db});
        checkOutput($sformatf("v%0d_txn_count", idx), txn_q.size(), v.ntx);
        for (int k = 0; k < v.ntx && k < txn_q.size(); k++) begin
            checkOutput($sformatf("v%0d_txn%0d_addr", idx, k), {16'b0, txn_q[k]}, {16'b0, v.tx[k]});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        spurious    = 1'b0;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFF] = 8'hC1; mem[16'h0000] = 8'h23;
        mem[16'h0123] = 8'h80; mem[16'h0124] = 8'h2A;
        mem[16'h0125] = 8'h89; mem[16'h0126] = 8'h07;
        mem[16'h0127] = 8'h82; mem[16'h0128] = 8'h00; mem[16'h0129] = 8'h5C;
        mem[16'h012A] = 8'h84; mem[16'h012B] = 8'h03;
        mem[16'hFE06] = 8'hBE; mem[16'hFE07] = 8'hEF;
        mem[16'h012C] = 8'h90; mem[16'h012D] = 8'h11;
        mem[16'h012E] = 8'h00; mem[16'h012F] = 8'h00;
        mem[16'h0130] = 8'h40; mem[16'h0131] = 8'h00;
        mem[16'h0132] = 8'h8A; mem[16'h0133] = 8'h00; mem[16'h0134] = 8'h77;
        mem[16'h0135] = 8'hC0; mem[16'h0136] = 8'h10;

        vecs[0] = mk(16'hC123, 16'h0123, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 2, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
        vecs[1] = mk(16'h802A, 16'h0125, 16'h1000, 1'b1, 16'h002A, 1'b0, 8'h00, 2, 16'h0123, 16'h0124, 16'h0, 16'h0);
        vecs[2] = mk(16'h8907, 16'h0127, 16'h0100, 1'b1, 16'h0700, 1'b0, 8'h00, 2, 16'h0125, 16'h0126, 16'h0, 16'h0);
        vecs[3] = mk(16'h8200, 16'h012A, 16'h1000, 1'b1, 16'h005C, 1'b1, 8'h5C, 3, 16'h0127, 16'h0128, 16'h0129, 16'h0);
        vecs[4] = mk(16'h8403, 16'h012C, 16'h1000, 1'b1, 16'hBEEF, 1'b1, 8'h5C, 4, 16'h012A, 16'h012B, 16'hFE06, 16'hFE07);
        vecs[5] = mk(16'h9011, 16'h012E, 16'h0010, 1'b1, 16'h0011, 1'b1, 8'h5C, 2, 16'h012C, 16'h012D, 16'h0, 16'h0);
        vecs[6] = mk(16'h0000, 16'h0130, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h5C, 2, 16'h012E, 16'h012F, 16'h0, 16'h0);
        vecs[7] = mk(16'h4000, 16'h0132, 16'h0001, 1'b0, 16'h0000, 1'b1, 8'h5C, 2, 16'h0130, 16'h0131, 16'h0, 16'h0);
        vecs[8] = mk(16'h8A00, 16'h0135, 16'h0100, 1'b1, 16'h0077, 1'b1, 8'h77, 3, 16'h0132, 16'h0133, 16'h0134, 16'h0);
        vecs[9] = mk(16'hC010, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h77, 2, 16'h0135, 16'h0136, 16'h0, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_pc", {16'b0, pc}, 32'h0000FFFF);
        checkOutput("reset_ir", {16'b0, ir}, 32'd0);
        checkOutput("reset_data_byte", {24'b0, data_byte}, 32'd0);
        checkOutput("reset_dec_en", {31'b0, dec_en}, 32'd0);
        checkOutput("reset_strobes", {28'b0, exec_load, exec_add, exec_out_lo, illegal}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(i);

        // Fetch at 0x0010 is now outstanding; stall the ack and reset mid-transaction
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("stall_mem_addr", {16'b0, mem_addr}, 32'h00000010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("midreset_pc", {16'b0, pc}, 32'h0000FFFF);
        checkOutput("midreset_ir", {16'b0, ir}, 32'd0);
        checkOutput("midreset_data_byte", {24'b0, data_byte}, 32'd0);

        // Ack presented while no request is outstanding must be ignored
        @(negedge clk);
        rst      = 1'b0;
        stall    = 1'b0;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        checkOutput("restart_mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("restart_mem_addr", {16'b0, mem_addr}, 32'h0000FFFF);
        checkOutput("spurious_ack_ir", {16'b0, ir}, 32'd0);
        checkOutput("spurious_ack_pc", {16'b0, pc}, 32'h0000FFFF);
        applyStimulus(0);
        applyStimulus(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
